// File: rtl/fir_pkg.sv
// Shared state encoding and arithmetic helpers for fir_mac_scheduler.
// Result reduction saturates when FIR_SAT_EN is defined, otherwise wraps.
package fir_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        MAC,
        OUT
    } fir_state_t;

    function automatic int acc_width(input int width, input int ntaps);
        return 2 * width + $clog2(ntaps);
    endfunction

    function automatic logic [63:0] reduce_result(input logic [63:0] shifted,
                                                  input int unsigned width);
        logic [63:0] max_val;
        max_val = (64'd1 << width) - 64'd1;
`ifdef FIR_SAT_EN
        return (shifted > max_val) ? max_val : shifted;
`else
        return shifted & max_val;
`endif
    endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// NTAPS-deep sample history: one write port, one clear-slot port and a
// combinational read at (base - offset) wrapped modulo NTAPS.
module fir_sample_ring #(
    parameter int WIDTH = 8,
    parameter int NTAPS = 16
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(NTAPS)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     clr_en,
    input  logic [$clog2(NTAPS)-1:0] clr_addr,
    input  logic [$clog2(NTAPS)-1:0] rd_base,
    input  logic [$clog2(NTAPS)-1:0] rd_offset,
    output logic [WIDTH-1:0]         rd_data
);

    localparam int AW = $clog2(NTAPS);
    localparam logic [AW:0] NT = (AW+1)'(NTAPS);

    logic [WIDTH-1:0] slots [NTAPS];
    logic [AW-1:0]    rd_idx;

    always_ff @(posedge clock) begin
        if (clr_en) begin
            slots[clr_addr] <= '0;
        end else if (wr_en) begin
            slots[wr_addr] <= wr_data;
        end
    end

    // Explicit wrap keeps non-power-of-two NTAPS correct.
    always_comb begin
        rd_idx = rd_base - rd_offset;
        if (rd_base < rd_offset) begin
            rd_idx = AW'({1'b0, rd_base} + NT - {1'b0, rd_offset});
        end
        rd_data = slots[rd_idx];
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR: one shared MAC, one tap per cycle, runtime coefficient bank.
// Output reduction is selected by FIR_SAT_EN (saturate) or wraps when undefined.
module fir_mac_scheduler
    import fir_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NTAPS = 16,
    parameter int FRAC  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [WIDTH-1:0]         coef_data,
    output logic                     coef_busy
);

    localparam int AW   = $clog2(NTAPS);
    localparam int ACCW = acc_width(WIDTH, NTAPS);
    localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);
    localparam logic [AW:0]   NT   = (AW+1)'(NTAPS);

    fir_state_t state, next_state;

    logic [AW-1:0]      tap;
    logic [AW-1:0]      wr_ptr;
    logic [ACCW-1:0]    acc;
    logic [ACCW-1:0]    acc_next;
    logic [WIDTH-1:0]   coef [NTAPS];
    logic [WIDTH-1:0]   hist_data;
    logic [2*WIDTH-1:0] product;
    logic               last_tap;
    logic               accept;
    logic               coef_wr;

    assign accept  = in_valid & in_ready;
    assign coef_wr = coef_we & (state == IDLE) & ~reset & ({1'b0, coef_addr} < NT);

    fir_sample_ring #(
        .WIDTH (WIDTH),
        .NTAPS (NTAPS)
    ) u_ring (
        .clock     (clock),
        .wr_en     (accept & ~reset),
        .wr_addr   (wr_ptr),
        .wr_data   (in_data),
        .clr_en    ((state == CLEAR) & ~reset),
        .clr_addr  (tap),
        .rd_base   (wr_ptr),
        .rd_offset (tap),
        .rd_data   (hist_data)
    );

    always_comb begin
        next_state = state;
        last_tap   = (tap == LAST);
        product    = (2*WIDTH)'(coef[tap]) * (2*WIDTH)'(hist_data);
        acc_next   = acc + ACCW'(product);
        unique case (state)
            CLEAR: if (last_tap)  next_state = IDLE;
            IDLE:  if (accept)    next_state = MAC;
            MAC:   if (last_tap)  next_state = OUT;
            OUT:   if (out_ready) next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Handshake flags are registered from next_state so they track state with no combinational input path.
    always_ff @(posedge clock) begin
        if (reset) begin
            tap       <= '0;
            wr_ptr    <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            coef_busy <= 1'b1;
        end else begin
            out_valid <= (next_state == OUT);
            in_ready  <= (next_state == IDLE);
            coef_busy <= (next_state != IDLE);
            unique case (state)
                CLEAR: tap <= last_tap ? '0 : tap + AW'(1);
                IDLE: begin
                    if (accept) begin
                        acc <= '0;
                        tap <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (last_tap) begin
                        tap      <= '0;
                        wr_ptr   <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
                        out_data <= WIDTH'(reduce_result(64'(acc_next >> FRAC), WIDTH));
                    end else begin
                        tap <= tap + AW'(1);
                    end
                end
                OUT: ;
            endcase
        end
    end

    // Coefficient bank deliberately survives reset.
    always_ff @(posedge clock) begin
        if (coef_wr) begin
            coef[coef_addr] <= coef_data;
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Scoreboard bench for fir_mac_scheduler: a behavioural FIR model predicts each
// output, a negedge monitor pops and compares whenever a result transfers.
`timescale 1ns/1ps
module tb_fir_mac_scheduler;

    localparam int WIDTH = 8;
    localparam int NTAPS = 16;
    localparam int FRAC  = 8;
    localparam int AW    = $clog2(NTAPS);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic             coef_we = 1'b0;
    logic [AW-1:0]    coef_addr = '0;
    logic [WIDTH-1:0] coef_data = '0;
    logic             coef_busy;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    int unsigned      mcoef [NTAPS];
    int unsigned      hist  [NTAPS];
    bit               rand_bp = 1'b0;

    always #5 clock = ~clock;

    fir_mac_scheduler #(
        .WIDTH (WIDTH),
        .NTAPS (NTAPS),
        .FRAC  (FRAC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_busy (coef_busy)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // y[n] = (sum_k c[k] * x[n-k]) >> FRAC, reduced to WIDTH bits.
    function automatic logic [WIDTH-1:0] model_push(input int unsigned x);
        longint unsigned acc = 0;
        for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
        for (int k = 0; k < NTAPS; k++) acc += 64'(mcoef[k]) * 64'(hist[k]);
        acc = acc >> FRAC;
`ifdef FIR_SAT_EN
        if (acc > 64'((2**WIDTH) - 1)) acc = 64'((2**WIDTH) - 1);
`endif
        return WIDTH'(acc);
    endfunction

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got out_data 0x%0h with no result pending", out_data);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string who);
        int n = 0;
        while (!in_ready && n < 400) begin
            out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: in_ready=0 after %0d cycles, required 1", who, n);
        end
    endtask

    task automatic write_coef(input int unsigned addr, input logic [WIDTH-1:0] data);
        wait_ready("coef");
        coef_we   = 1'b1;
        coef_addr = AW'(addr);
        coef_data = data;
        step();
        coef_we = 1'b0;
        if (addr < NTAPS) mcoef[addr] = data;
    endtask

    task automatic send(input logic [WIDTH-1:0] x, input bit we,
                        input int unsigned addr, input logic [WIDTH-1:0] data);
        wait_ready("send");
        in_valid = 1'b1;
        in_data  = x;
        if (we) begin
            coef_we   = 1'b1;
            coef_addr = AW'(addr);
            coef_data = data;
            mcoef[addr] = data;
        end
        exp_q.push_back(model_push(x));
        step();
        in_valid = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) step();
        reset = 1'b0;
        exp_q.delete();
        for (int k = 0; k < NTAPS; k++) hist[k] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        logic [WIDTH-1:0] held;

        // Reset with in_valid asserted: in_ready low for exactly NTAPS cycles.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        reset    = 1'b1;
        step();
        step();
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        reset = 1'b0;
        for (int i = 0; i <= NTAPS; i++) begin
            if (i > 0) step();
            check($sformatf("clear_in_ready_c%0d", i), in_ready, (i == NTAPS));
            check($sformatf("clear_out_valid_c%0d", i), out_valid, 0);
        end
        in_valid = 1'b0;

        // Single tap: 0x80 * 0x40 >> 8 = 0x20, NTAPS+1 cycles after the handshake.
        for (int k = 0; k < NTAPS; k++) write_coef(k, (k == 0) ? 8'h40 : 8'h00);
        wait_ready("lat");
        in_valid = 1'b1;
        in_data  = 8'h80;
        exp_q.push_back(model_push(8'h80));
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        check("latency", lat, NTAPS + 1);
        check("single_tap_data", out_data, 8'h20);

        // Impulse response after reset; coefficients written before it are rewritten here.
        do_reset(2);
        for (int k = 0; k < NTAPS; k++) write_coef(k, WIDTH'(k + 1));
        send(8'hFF, 0, 0, 0);
        for (int i = 1; i < NTAPS; i++) send(8'h00, 0, 0, 0);

        // Overflow: all-ones coefficients and samples.
        for (int k = 0; k < NTAPS; k++) write_coef(k, 8'hFF);
        for (int i = 0; i < NTAPS; i++) send(8'hFF, 0, 0, 0);
        wait_ready("ovf_drain");
        check("overflow_last", out_data,
`ifdef FIR_SAT_EN
              8'hFF
`else
              8'hE0
`endif
        );

        // Backpressure: result held for 50 cycles, upstream stalled.
        for (int k = 0; k < NTAPS; k++) write_coef(k, WIDTH'($urandom_range(0, 255)));
        send(8'h37, 0, 0, 0);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        check("bp_out_valid", out_valid, 1);
        held = out_data;
        for (int i = 0; i < 50; i++) begin
            step();
            check($sformatf("bp_hold_data_c%0d", i), out_data, held);
            check($sformatf("bp_hold_in_ready_c%0d", i), in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);

        // Coefficient writes during MAC must be ignored.
        send(8'h91, 0, 0, 0);
        coef_we = 1'b1;
        for (int i = 0; i < NTAPS; i++) begin
            coef_addr = AW'(i);
            coef_data = ~WIDTH'(mcoef[i]);
            check($sformatf("mac_coef_busy_t%0d", i), coef_busy, 1);
            step();
        end
        coef_we = 1'b0;
        send(8'h23, 0, 0, 0);

        // Reset mid-MAC: no output, history cleared, coefficients kept.
        for (int k = 0; k < NTAPS; k++) write_coef(k, WIDTH'($urandom_range(1, 255)));
        send(8'hAA, 0, 0, 0);
        repeat (5) step();
        do_reset(1);
        for (int i = 1; i <= NTAPS; i++) begin
            step();
            check($sformatf("abort_out_valid_c%0d", i), out_valid, 0);
        end
        check("abort_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) send(WIDTH'($urandom_range(0, 255)), 0, 0, 0);

        // Randomised traffic with concurrent coefficient writes and random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                write_coef($urandom_range(0, NTAPS - 1), WIDTH'($urandom_range(0, 255)));
            send(WIDTH'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, NTAPS - 1), WIDTH'($urandom_range(0, 255)));
        end
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            step();
            n++;
        end
        check("drain_pending", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
